// File: rtl/cfnp_pkg.sv
// CFNP layer scheduler: shared types, state encoding and per-layer table.
package cfnp_pkg;

   localparam int MAX_LAYERS  = 8;
   localparam int DEF_TIMEOUT = 4096;
   localparam int CFG_W       = 16;

   typedef struct packed {
      logic [CFG_W-1:0] in_len;
      logic [3:0]       kernel;
      logic [CFG_W-1:0] wbase;
      logic             relu;
   } layer_cfg_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      KICK,
      WAIT,
      NEXT,
      FINISH
   } sched_state_t;

   // Fields are wider than the default ports; the top keeps the low bits.
   localparam layer_cfg_t LAYER_CFG [0:MAX_LAYERS-1] = '{
      '{in_len: 16'd1000, kernel: 4'd7, wbase: 16'h000, relu: 1'b1},
      '{in_len: 16'd496,  kernel: 4'd5, wbase: 16'h040, relu: 1'b1},
      '{in_len: 16'd244,  kernel: 4'd5, wbase: 16'h0a0, relu: 1'b1},
      '{in_len: 16'd120,  kernel: 4'd3, wbase: 16'h100, relu: 1'b0},
      '{in_len: 16'd60,   kernel: 4'd3, wbase: 16'h130, relu: 1'b1},
      '{in_len: 16'd30,   kernel: 4'd3, wbase: 16'h150, relu: 1'b1},
      '{in_len: 16'd16,   kernel: 4'd3, wbase: 16'h170, relu: 1'b1},
      '{in_len: 16'd8,    kernel: 4'd1, wbase: 16'h190, relu: 1'b0}
   };

endpackage

// File: rtl/cfnp_watchdog.sv
// Engine watchdog: counts enabled cycles since the last clear.
module cfnp_watchdog
   import cfnp_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   logic [15:0] cnt;
   logic [15:0] cnt_inc;

   // cnt_inc numbers the current enabled cycle, so expiry hits on cycle TIMEOUT-1
   assign cnt_inc = cnt + 16'd1;
   assign expire  = enable & (cnt_inc == 16'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt_inc;
      end
   end

endmodule

// File: rtl/cfnp_layer_sched.sv
// Layer sequencer: steps the shared MAC engine through every CNN layer
// of a frame, ping-ponging the feature buffers and guarding with a watchdog.
module cfnp_layer_sched
   import cfnp_pkg::*;
#(
   parameter int NUM_LAYERS = 4,
   parameter int ADDR_W     = 12,
   parameter int LEN_W      = 12,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          abort,
   input  logic                          eng_done,
   output logic                          eng_start,
   output logic [$clog2(NUM_LAYERS)-1:0] layer_idx,
   output logic [LEN_W-1:0]              cfg_in_len,
   output logic [3:0]                    cfg_kernel,
   output logic [ADDR_W-1:0]             cfg_wbase,
   output logic                          relu_en,
   output logic                          src_buf,
   output logic                          dst_buf,
   output logic                          busy,
   output logic                          done,
   output logic                          err
);

   localparam int            IW   = $clog2(NUM_LAYERS);
   localparam logic [IW-1:0] LAST = IW'(NUM_LAYERS - 1);

   sched_state_t state, nstate;

   logic              wd_clear;
   logic              wd_en;
   logic              wd_exp;
   logic              is_last;
   logic [2:0]        tidx;
   logic              eng_start_d;
   logic [IW-1:0]     idx_d;
   logic [LEN_W-1:0]  len_d;
   logic [3:0]        kern_d;
   logic [ADDR_W-1:0] wbase_d;
   logic              relu_d;
   logic              src_d;
   logic              busy_d;
   logic              done_d;
   logic              err_d;

   assign wd_clear = (state == KICK);
   assign wd_en    = (state == WAIT);
   assign is_last  = (layer_idx == LAST);
   assign tidx     = 3'(layer_idx);
   assign dst_buf  = ~src_buf;

   cfnp_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_wd (
      .clk   (clk),
      .rst   (rst),
      .clear (wd_clear),
      .enable(wd_en),
      .expire(wd_exp)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         eng_start  <= 1'b0;
         layer_idx  <= '0;
         cfg_in_len <= '0;
         cfg_kernel <= '0;
         cfg_wbase  <= '0;
         relu_en    <= 1'b0;
         src_buf    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= nstate;
         eng_start  <= eng_start_d;
         layer_idx  <= idx_d;
         cfg_in_len <= len_d;
         cfg_kernel <= kern_d;
         cfg_wbase  <= wbase_d;
         relu_en    <= relu_d;
         src_buf    <= src_d;
         busy       <= busy_d;
         done       <= done_d;
         err        <= err_d;
      end
   end

   always_comb begin
      nstate = state;
      unique case (state)
         IDLE:    if (start) nstate = LOAD;
         LOAD:    nstate = KICK;
         KICK:    nstate = WAIT;
         WAIT: begin
            // a done arriving on the expiry cycle still counts
            if (eng_done)    nstate = NEXT;
            else if (wd_exp) nstate = IDLE;
         end
         NEXT:    nstate = is_last ? FINISH : LOAD;
         FINISH:  nstate = IDLE;
         default: nstate = IDLE;
      endcase
      if (abort) nstate = IDLE;
   end

   always_comb begin
      eng_start_d = (nstate == KICK);
      done_d      = (nstate == FINISH);
      busy_d      = (nstate == LOAD) || (nstate == KICK) ||
                    (nstate == WAIT) || (nstate == NEXT);
      idx_d       = layer_idx;
      src_d       = src_buf;
      err_d       = err;
      len_d       = cfg_in_len;
      kern_d      = cfg_kernel;
      wbase_d     = cfg_wbase;
      relu_d      = relu_en;
      if (state == IDLE && nstate == LOAD) begin
         idx_d = '0;
         src_d = 1'b0;
         err_d = 1'b0;
      end
      if (state == NEXT && nstate == LOAD) begin
         idx_d = layer_idx + 1'b1;
         src_d = ~src_buf;
      end
      if (state == WAIT && nstate == IDLE && !abort) begin
         err_d = 1'b1;
      end
      if (state == LOAD && nstate == KICK) begin
         len_d   = LAYER_CFG[tidx].in_len[LEN_W-1:0];
         kern_d  = LAYER_CFG[tidx].kernel;
         wbase_d = LAYER_CFG[tidx].wbase[ADDR_W-1:0];
         relu_d  = LAYER_CFG[tidx].relu & ~is_last;
      end
   end

endmodule

// File: tb/tb_cfnp_layer_sched.sv
// Scoreboard bench for cfnp_layer_sched: timed event model vs. DUT pulses.
module tb_cfnp_layer_sched;
   import cfnp_pkg::*;

   localparam int L       = 4;
   localparam int TO      = 100;
   localparam int K_START = 0;
   localparam int K_DONE  = 1;
   localparam int K_ERR   = 2;

   logic        clk;
   logic        rst;
   logic        start;
   logic        abort;
   logic        eng_done;
   logic        eng_start;
   logic [1:0]  layer_idx;
   logic [11:0] cfg_in_len;
   logic [3:0]  cfg_kernel;
   logic [11:0] cfg_wbase;
   logic        relu_en;
   logic        src_buf;
   logic        dst_buf;
   logic        busy;
   logic        done;
   logic        err;

   typedef struct {
      int          kind;
      longint      cyc;
      logic [63:0] data;
   } ev_t;

   ev_t    sbq[$];
   int     n_chk = 0;
   int     n_pass = 0;
   longint cyc = 0;
   logic   spur = 1'b0;
   logic   eng_resp = 1'b0;
   bit     eng_on = 1'b1;
   int     eng_delay = 10;
   int     eng_cnt = -1;

   assign eng_done = spur | eng_resp;

   cfnp_layer_sched #(
      .NUM_LAYERS(L),
      .ADDR_W    (12),
      .LEN_W     (12),
      .TIMEOUT   (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .eng_done  (eng_done),
      .eng_start (eng_start),
      .layer_idx (layer_idx),
      .cfg_in_len(cfg_in_len),
      .cfg_kernel(cfg_kernel),
      .cfg_wbase (cfg_wbase),
      .relu_en   (relu_en),
      .src_buf   (src_buf),
      .dst_buf   (dst_buf),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout act=running req=finished");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s act=%0h exp=%0h cyc=%0d", nm, act, exp, cyc);
   endtask

   function automatic logic [63:0] pk(int idx, logic src, logic dst,
                                      logic [15:0] len, logic [3:0] k,
                                      logic [15:0] wb, logic relu);
      return {22'd0, 3'(idx), src, dst, len, k, wb, relu};
   endfunction

   // Layer i reads buffer i%2, writes the other; only the last skips ReLU.
   function automatic logic [63:0] exp_layer(int i);
      return pk(i, 1'(i % 2), 1'((i + 1) % 2), LAYER_CFG[i].in_len,
                LAYER_CFG[i].kernel, LAYER_CFG[i].wbase, i != L - 1);
   endfunction

   // Frame whose start is driven at negedge s, engine time e per layer.
   task automatic expect_frame(input longint s, input int e,
                               input int nl, input bit fin);
      ev_t ev;
      for (int i = 0; i < nl; i++) begin
         ev.kind = K_START;
         ev.cyc  = s + 2 + longint'(i) * (3 + e);
         ev.data = exp_layer(i);
         sbq.push_back(ev);
      end
      if (fin) begin
         ev.kind = K_DONE;
         ev.cyc  = s + longint'(L) * (3 + e) + 1;
         ev.data = '0;
         sbq.push_back(ev);
      end
   endtask

   task automatic got(input int kind, input logic [63:0] data);
      ev_t ev;
      if (sbq.size() == 0) begin
         n_chk++;
         $display("FAIL sb_unexpected kind=%0d cyc=%0d act=event req=none",
                  kind, cyc);
      end else begin
         ev = sbq.pop_front();
         chk("ev_kind", 64'(kind), 64'(ev.kind));
         chk("ev_cyc", 64'(cyc), 64'(ev.cyc));
         chk("ev_data", data, ev.data);
      end
   endtask

   task automatic wait_until(input longint c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic run_frame(input int e);
      longint s;
      s = cyc;
      eng_delay = e;
      expect_frame(s, e, L, 1'b1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_on", 64'(busy), 64'd1);
      chk("err_clr", 64'(err), 64'd0);
      wait_until(s + longint'(L) * (3 + e) + 2);
      chk("busy_end", 64'(busy), 64'd0);
      chk("done_end", 64'(done), 64'd0);
   endtask

   // Engine model: eng_done becomes visible eng_delay cycles after eng_start.
   initial forever begin
      @(negedge clk);
      eng_resp = 1'b0;
      if (eng_cnt > 0) begin
         eng_cnt--;
         if (eng_cnt == 0) begin
            eng_resp = 1'b1;
            eng_cnt  = -1;
         end
      end
      if (eng_start && eng_on) eng_cnt = eng_delay;
   end

   initial begin
      logic err_q;
      err_q = 1'b0;
      forever begin
         @(negedge clk);
         if (eng_start)
            got(K_START, pk(int'(layer_idx), src_buf, dst_buf,
                            16'(cfg_in_len), cfg_kernel,
                            16'(cfg_wbase), relu_en));
         if (done) got(K_DONE, '0);
         if (err && !err_q) got(K_ERR, '0);
         err_q = err;
      end
   end

   initial begin
      longint s;
      ev_t    ev;
      int     e;
      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_dst", 64'(dst_buf), 64'd1);
      chk("rst_outs", 64'({eng_start, layer_idx, cfg_in_len, cfg_kernel,
                           cfg_wbase, relu_en, src_buf, busy, done, err}),
          64'd0);

      run_frame(10);

      // engine silent: watchdog fires
      s = cyc;
      eng_on = 1'b0;
      expect_frame(s, 0, 1, 1'b0);
      ev.kind = K_ERR;
      ev.cyc  = s + 2 + TO;
      ev.data = '0;
      sbq.push_back(ev);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_until(s + 3 + TO);
      chk("wd_err", 64'(err), 64'd1);
      chk("wd_busy", 64'(busy), 64'd0);
      eng_on = 1'b1;
      repeat (3) @(negedge clk);
      run_frame(6);

      // abort in WAIT of layer 2
      s = cyc;
      eng_delay = 20;
      expect_frame(s, 20, 3, 1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_until(s + 51);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_kick", 64'(eng_start), 64'd0);
      repeat (3) @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort", 64'(busy), 64'd0);
      repeat (40) @(negedge clk);
      run_frame(7);

      // spurious eng_done in IDLE and KICK, start re-pulsed mid-frame
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      @(negedge clk);
      s = cyc;
      eng_delay = 12;
      expect_frame(s, 12, L, 1'b1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_until(s + 20);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_until(s + 32);
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      wait_until(s + 62);
      chk("spur_busy", 64'(busy), 64'd0);

      // async reset in WAIT of layer 3
      repeat (2) @(negedge clk);
      s = cyc;
      eng_delay = 8;
      expect_frame(s, 8, L, 1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_until(s + 37);
      #3 rst = 1'b1;
      #1;
      chk("arst_dst", 64'(dst_buf), 64'd1);
      chk("arst_outs", 64'({eng_start, layer_idx, cfg_in_len, cfg_kernel,
                            cfg_wbase, relu_en, src_buf, busy, done, err}),
          64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("post_rst_idle", 64'({busy, layer_idx, src_buf}), 64'd0);

      // eng_done lands on the expiry cycle
      run_frame(TO - 1);
      chk("coinc_err", 64'(err), 64'd0);

      for (int r = 0; r < 4; r++) begin
         e = $urandom_range(1, 25);
         repeat ($urandom_range(1, 6)) @(negedge clk);
         if ($urandom_range(0, 1) == 1) begin
            spur = 1'b1;
            @(negedge clk);
            spur = 1'b0;
         end
         run_frame(e);
      end

      repeat (5) @(negedge clk);
      chk("sb_left", 64'(sbq.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
